// File: rtl/data_mem_lsu_pkg.sv
// Shared types for the data memory load/store unit: access sizes, LSU states
// and a funct3 decode helper for the execute stage.
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10,
    MEM_X = 2'b11
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } lsu_state_t;

  localparam int MAX_READ_LATENCY = 4;

  // funct3[2] is the unsigned flag for loads; the low two bits map directly onto the size.
  function automatic mem_size_t funct3_to_size(input logic [2:0] funct3);
    return mem_size_t'(funct3[1:0]);
  endfunction

endpackage

// File: rtl/data_mem_lsu_load_ext.sv
// Load extension: takes the raw little-endian word starting at the addressed
// byte and sign- or zero-extends the byte/half, or passes a word through.
module load_ext
  import mem_pkg::*;
(
  input  logic [31:0] i_raw,
  input  mem_size_t   i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  always_comb begin
    o_data = i_raw;
    case (i_size)
      MEM_B:   o_data = {{24{i_raw[7] & ~i_unsigned}}, i_raw[7:0]};
      MEM_H:   o_data = {{16{i_raw[15] & ~i_unsigned}}, i_raw[15:0]};
      MEM_W:   o_data = i_raw;
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_lsu.sv
// Byte-addressed little-endian data memory with a one-outstanding-request
// handshake, configurable load latency and alignment/range error reporting.
module data_mem_lsu
  import mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0001_0000,
  parameter int          DEPTH_BYTES  = 2**17,
  parameter int          READ_LATENCY = 1,
  parameter string       INIT_FILE    = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  mem_size_t   req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_BYTES);

  generate
    if ((READ_LATENCY < 1) || (READ_LATENCY > MAX_READ_LATENCY)) begin : g_badLatency
      $error("data_mem_lsu: READ_LATENCY must be in 1..%0d", MAX_READ_LATENCY);
    end
    if ((DEPTH_BYTES < 4) || ((DEPTH_BYTES & (DEPTH_BYTES - 1)) != 0)) begin : g_badDepth
      $error("data_mem_lsu: DEPTH_BYTES must be a power of two >= 4");
    end
  endgenerate

  logic [7:0] r_mem [DEPTH_BYTES];

  lsu_state_t     r_state;
  lsu_state_t     w_nextState;
  logic [2:0]     r_cnt;
  logic [2:0]     w_nextCnt;
  logic [AW-1:0]  r_idx;
  mem_size_t      r_size;
  logic           r_unsigned;
  logic           r_rspValid;
  logic [31:0]    r_rspRdata;
  logic           r_rspErr;

  logic [31:0]    w_off;
  logic [AW-1:0]  w_idx;
  logic           w_err;
  logic           w_accept;
  logic           w_fromIdle;
  logic [AW-1:0]  w_rdIdx;
  mem_size_t      w_rdSize;
  logic           w_rdUnsigned;
  logic [31:0]    w_raw;
  logic [31:0]    w_ext;

  assign w_off      = req_addr - BASE_ADDR;
  assign w_idx      = w_off[AW-1:0];
  assign w_err      = (w_off >= 32'(DEPTH_BYTES))
                    || (req_size == MEM_X)
                    || ((req_size == MEM_H) && req_addr[0])
                    || ((req_size == MEM_W) && (req_addr[1:0] != 2'b00));
  assign w_fromIdle = (r_state == IDLE);
  assign w_accept   = req_valid && w_fromIdle;
  assign req_ready  = w_fromIdle;

  // Single-cycle responses sample the live request; multi-cycle loads use the captured copy.
  assign w_rdIdx      = w_fromIdle ? w_idx : r_idx;
  assign w_rdSize     = w_fromIdle ? req_size : r_size;
  assign w_rdUnsigned = w_fromIdle ? req_unsigned : r_unsigned;
  assign w_raw = {r_mem[w_rdIdx + AW'(3)], r_mem[w_rdIdx + AW'(2)],
                  r_mem[w_rdIdx + AW'(1)], r_mem[w_rdIdx]};

  load_ext u_loadExt (
    .i_raw      (w_raw),
    .i_size     (w_rdSize),
    .i_unsigned (w_rdUnsigned),
    .o_data     (w_ext)
  );

  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (req_we || w_err || (READ_LATENCY == 1)) begin
            w_nextState = RESP;
          end else begin
            w_nextState = WAIT;
            w_nextCnt   = 3'd1;
          end
        end
      end
      WAIT: begin
        if (r_cnt == 3'(READ_LATENCY - 1)) begin
          w_nextState = RESP;
          w_nextCnt   = '0;
        end else begin
          w_nextCnt = r_cnt + 3'd1;
        end
      end
      RESP:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_rspValid <= 1'b0;
      r_rspRdata <= '0;
      r_rspErr   <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_cnt      <= w_nextCnt;
      r_rspValid <= (w_nextState == RESP);
      if (w_accept) begin
        r_idx      <= w_idx;
        r_size     <= req_size;
        r_unsigned <= req_unsigned;
      end
      if (w_nextState == RESP) begin
        r_rspErr   <= w_fromIdle && w_err;
        r_rspRdata <= (w_fromIdle && (req_we || w_err)) ? '0 : w_ext;
      end
    end
  end

  // Stores land on the accept edge, so any later load sees them.
  always_ff @(posedge clk) begin
    if (!rst && w_accept && req_we && !w_err) begin
      case (req_size)
        MEM_B: r_mem[w_idx] <= req_wdata[7:0];
        MEM_H: begin
          r_mem[w_idx]          <= req_wdata[7:0];
          r_mem[w_idx + AW'(1)] <= req_wdata[15:8];
        end
        MEM_W: begin
          r_mem[w_idx]          <= req_wdata[7:0];
          r_mem[w_idx + AW'(1)] <= req_wdata[15:8];
          r_mem[w_idx + AW'(2)] <= req_wdata[23:16];
          r_mem[w_idx + AW'(3)] <= req_wdata[31:24];
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = r_rspValid;
  assign rsp_rdata = r_rspRdata;
  assign rsp_err   = r_rspErr;

endmodule
